// File: rtl/cfeb_fifo_responder.sv
// cfeb_fifo_responder: FWFT read-side responder for one CFEB data FIFO channel
module cfeb_fifo_responder #(
   parameter int AW = 8,
   parameter int DW = 18
) (
   input  logic          CLKDDU,
   input  logic          RST_B,
   input  logic          FIFOMRST,
   input  logic          WR_EN,
   input  logic [DW-1:0] WR_DATA,
   input  logic          WR_LAST,
   input  logic          RENFIFO_B,
   input  logic          OEFIFO_B,
   output logic [DW-1:0] DOUT,
   output logic          LAST_OUT,
   output logic          FFOR_B,
   output logic          FULL_B,
   output logic          HALF,
   output logic [AW:0]   WCNT,
   output logic [AW:0]   EVT_CNT,
   output logic          DAV,
   output logic          OVFL,
   output logic          UNDF
);
   localparam int CAP = 1 << AW;
   // The LOAD step is the combinational load strobe, so an EMPTY register
   // with data in RAM becomes VALID on the very next edge.
   localparam logic EMPTY = 1'b0;
   localparam logic VALID = 1'b1;

   logic [DW:0]   mem [CAP];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   ram_cnt, evt_cnt, evt_nxt;
   logic [DW:0]   out_q;
   logic          state, dav, ovfl, undf;
   logic          full, rd_ok, wr_ok, load;

   // Accept/drop decisions and the next event count
   always_comb begin
      full    = ram_cnt == (AW+1)'(CAP);
      rd_ok   = !RENFIFO_B && state == VALID;
      wr_ok   = WR_EN && (!full || rd_ok);
      load    = (state == EMPTY || rd_ok) && ram_cnt != '0;
      evt_nxt = evt_cnt + (AW+1)'(wr_ok && WR_LAST) - (AW+1)'(rd_ok && out_q[DW]);
   end

   // RAM write port; the last flag rides in the top bit
   always_ff @(posedge CLKDDU) begin
      if (wr_ok && !FIFOMRST) mem[wp] <= {WR_LAST, WR_DATA};
   end

   // Pointers, output register fill, counts and sticky error flags
   always_ff @(posedge CLKDDU or negedge RST_B) begin
      if (!RST_B) begin
         wp <= '0; rp <= '0; ram_cnt <= '0; evt_cnt <= '0; out_q <= '0;
         state <= EMPTY; dav <= 1'b0; ovfl <= 1'b0; undf <= 1'b0;
      end else if (FIFOMRST) begin
         wp <= '0; rp <= '0; ram_cnt <= '0; evt_cnt <= '0; out_q <= '0;
         state <= EMPTY; dav <= 1'b0; ovfl <= 1'b0; undf <= 1'b0;
      end else begin
         if (wr_ok) wp <= wp + 1'b1;
         if (load) begin
            rp    <= rp + 1'b1;
            out_q <= mem[rp];
         end
         ram_cnt <= ram_cnt + (AW+1)'(wr_ok) - (AW+1)'(load);
         state   <= load ? VALID : rd_ok ? EMPTY : state;
         evt_cnt <= evt_nxt;
         dav     <= evt_nxt != '0;
         ovfl    <= ovfl | (WR_EN && !wr_ok);
         undf    <= undf | (!RENFIFO_B && state == EMPTY);
      end
   end

   assign DOUT     = OEFIFO_B ? '0 : out_q[DW-1:0];
   assign LAST_OUT = !OEFIFO_B && out_q[DW];
   assign FFOR_B   = state != VALID;
   assign FULL_B   = !full;
   assign WCNT     = ram_cnt + (AW+1)'(state);
   assign HALF     = WCNT >= (AW+1)'(CAP / 2);
   assign EVT_CNT  = evt_cnt;
   assign DAV      = dav;
   assign OVFL     = ovfl;
   assign UNDF     = undf;
endmodule

// File: tb/tb_cfeb_fifo_responder.sv
// tb_cfeb_fifo_responder: randomized bench against a queue-based FIFO model
module tb_cfeb_fifo_responder;
   localparam int AW = 8;
   localparam int DW = 18;
   localparam int CAP = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          fifomrst = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_last = 1'b0;
   logic          ren_b = 1'b1;
   logic          oe_b = 1'b0;
   logic [DW-1:0] dout;
   logic          last_out, ffor_b, full_b, half, dav, ovfl, undf;
   logic [AW:0]   wcnt, evt_cnt;

   int n_checks = 0;
   int n_fail = 0;

   // Model: every word held by the block, oldest first, plus whether the
   // oldest one is currently presented.
   logic [DW:0] q[$];
   bit          mv, movfl, mundf;

   cfeb_fifo_responder #(.AW(AW), .DW(DW)) dut (
      .CLKDDU(clk), .RST_B(rst_b), .FIFOMRST(fifomrst), .WR_EN(wr_en),
      .WR_DATA(wr_data), .WR_LAST(wr_last), .RENFIFO_B(ren_b), .OEFIFO_B(oe_b),
      .DOUT(dout), .LAST_OUT(last_out), .FFOR_B(ffor_b), .FULL_B(full_b),
      .HALF(half), .WCNT(wcnt), .EVT_CNT(evt_cnt), .DAV(dav), .OVFL(ovfl), .UNDF(undf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      mv = 0;
      movfl = 0;
      mundf = 0;
   endtask

   // One clock edge of the block, stated in terms of words held
   task automatic model_edge();
      int held, ram;
      bit rd, wr;
      if (fifomrst) begin
         model_clear();
         return;
      end
      held = q.size();
      ram = held - int'(mv);
      rd = !ren_b && mv;
      wr = wr_en && (ram < CAP || rd);
      if (!ren_b && !mv) mundf = 1;
      if (wr_en && !wr) movfl = 1;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back({wr_last, wr_data});
      // Only words already held before this edge (and not just read) can be presented
      mv = (held - int'(rd)) > 0;
   endtask

   task automatic check_all();
      int evts = 0;
      foreach (q[i]) evts += int'(q[i][DW]);
      check("ffor_b", 32'(ffor_b), 32'(!mv));
      if (mv) begin
         check("dout", 32'(dout), oe_b ? 32'd0 : 32'(q[0][DW-1:0]));
         check("last_out", 32'(last_out), oe_b ? 32'd0 : 32'(q[0][DW]));
      end else if (oe_b) begin
         check("dout_gated", 32'(dout), 32'd0);
      end
      check("wcnt", 32'(wcnt), 32'(q.size()));
      check("evt_cnt", 32'(evt_cnt), 32'(evts));
      check("dav", 32'(dav), 32'(evts != 0));
      check("full_b", 32'(full_b), 32'((q.size() - int'(mv)) != CAP));
      check("half", 32'(half), 32'(q.size() >= CAP / 2));
      check("ovfl", 32'(ovfl), 32'(movfl));
      check("undf", 32'(undf), 32'(mundf));
   endtask

   task automatic step(input bit we, input logic [DW-1:0] d, input bit l,
                       input bit ren, input bit oe, input bit mr);
      wr_en = we; wr_data = d; wr_last = l; ren_b = ren; oe_b = oe; fifomrst = mr;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic async_reset();
      #2 rst_b = 1'b0;
      #1 model_clear();
      check_all();
      #1 rst_b = 1'b1;
   endtask

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1 check_all();
      rst_b = 1'b1;
      // Single event word, one-cycle fall-through, then read it out
      step(1, 18'h2A5A5, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      check("single_word", 32'(dout), 32'h2A5A5);
      step(0, 0, 0, 0, 0, 0);
      // 100 words with two events, then continuous reads
      for (int i = 0; i < 100; i++) step(1, DW'(i), i == 49 || i == 99, 1, 0, 0);
      for (int i = 0; i < 102; i++) step(0, 0, 0, 0, 0, 0);
      // Fill to CAP+1, overflow, then write+read in one cycle
      step(0, 0, 0, 1, 0, 1);
      for (int i = 0; i < CAP + 1; i++) step(1, DW'($urandom), $urandom_range(0, 7) == 0, 1, 0, 0);
      check("full_wcnt", 32'(wcnt), 32'(CAP + 1));
      step(1, DW'($urandom), 0, 1, 0, 0);
      check("ovfl_set", 32'(ovfl), 32'd1);
      step(1, DW'($urandom), 1, 0, 0, 0);
      for (int i = 0; i < CAP + 4; i++) step(0, 0, 0, 0, 0, 0);
      // Underflow on empty, output gating with valid data
      step(0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      step(1, 18'h15A5A, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      // 600 words streamed across pointer wraps; HALF reached first
      step(0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 130; i++) step(1, DW'(i), $urandom_range(0, 9) == 0, 1, 0, 0);
      for (int i = 130; i < 600; i++) step(1, DW'(i), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, 0, 0);
      for (int i = 0; i < 140; i++) step(0, 0, 0, 0, 0, 0);
      // Random traffic with mid-stream asynchronous reset and master clear
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 300) == 0);
         if (i == 500) async_reset();
      end
      for (int i = 0; i < 20; i++) step(1, DW'($urandom), 1, 1, 0, 0);
      async_reset();
      for (int i = 0; i < 20; i++) step(1, DW'($urandom), 1, i % 2 == 0, 0, 0);
      step(1, DW'($urandom), 1, 0, 0, 1);
      check("mrst_wcnt", 32'(wcnt), 32'd0);
      step(0, 0, 0, 1, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
